// File: rtl/pl_id_ex_if.sv
// rtl/pl_id_ex_if.sv - ID/EX stage bus: decoded ID fields in, registered EX fields and stall/perf out
interface pl_id_ex_if #(
  parameter int WIDTH     = 32,
  parameter int REG_ADDR  = 5,
  parameter int CNT_WIDTH = 16
);
  // ID-side inputs to the stage
  logic                flush_e;
  logic                valid_d;
  logic                reg_wr_d;
  logic                ALU_source_d;
  logic                mem_wr_d;
  logic                pc_source2_d;
  logic [1:0]          reg_source_d;
  logic [2:0]          ALU_control_d;
  logic                branch_d;
  logic                jump_d;
  logic [2:0]          f3_d;
  logic [REG_ADDR-1:0] rs1_d;
  logic [REG_ADDR-1:0] rs2_d;
  logic [REG_ADDR-1:0] rd_d;
  logic [WIDTH-1:0]    rd1_d;
  logic [WIDTH-1:0]    rd2_d;
  logic [WIDTH-1:0]    imm_ext_d;
  logic [WIDTH-1:0]    pc_d;
  logic [WIDTH-1:0]    pc_plus4_d;

  // EX-side registered outputs
  logic                valid_e;
  logic                reg_wr_e;
  logic                ALU_source_e;
  logic                mem_wr_e;
  logic                pc_source2_e;
  logic [1:0]          reg_source_e;
  logic [2:0]          ALU_control_e;
  logic                branch_e;
  logic                jump_e;
  logic [2:0]          f3_e;
  logic [REG_ADDR-1:0] rs1_e;
  logic [REG_ADDR-1:0] rs2_e;
  logic [REG_ADDR-1:0] rd_e;
  logic [WIDTH-1:0]    rd1_e;
  logic [WIDTH-1:0]    rd2_e;
  logic [WIDTH-1:0]    imm_ext_e;
  logic [WIDTH-1:0]    pc_e;
  logic [WIDTH-1:0]    pc_plus4_e;

  // hazard and performance outputs
  logic                stall_f;
  logic                stall_d;
  logic [CNT_WIDTH-1:0] bubble_cnt;

  modport master (
    output flush_e, valid_d, reg_wr_d, ALU_source_d, mem_wr_d, pc_source2_d,
           reg_source_d, ALU_control_d, branch_d, jump_d, f3_d,
           rs1_d, rs2_d, rd_d, rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d,
    input  valid_e, reg_wr_e, ALU_source_e, mem_wr_e, pc_source2_e,
           reg_source_e, ALU_control_e, branch_e, jump_e, f3_e,
           rs1_e, rs2_e, rd_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e,
           stall_f, stall_d, bubble_cnt
  );

  modport slave (
    input  flush_e, valid_d, reg_wr_d, ALU_source_d, mem_wr_d, pc_source2_d,
           reg_source_d, ALU_control_d, branch_d, jump_d, f3_d,
           rs1_d, rs2_d, rd_d, rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d,
    output valid_e, reg_wr_e, ALU_source_e, mem_wr_e, pc_source2_e,
           reg_source_e, ALU_control_e, branch_e, jump_e, f3_e,
           rs1_e, rs2_e, rd_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e,
           stall_f, stall_d, bubble_cnt
  );
endinterface

// File: rtl/pl_id_ex_stage.sv
// rtl/pl_id_ex_stage.sv - ID/EX pipeline register with load-use bubble, flush squash and bubble counter
module pl_id_ex_stage #(
  parameter int WIDTH     = 32,
  parameter int REG_ADDR  = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  pl_id_ex_if.slave    bus
);

  // Everything that travels from ID into EX, kept as one word so a bubble is a single zero assignment.
  typedef struct packed {
    logic                valid;
    logic                reg_wr;
    logic                alu_source;
    logic                mem_wr;
    logic                pc_source2;
    logic [1:0]          reg_source;
    logic [2:0]          alu_control;
    logic                branch;
    logic                jump;
    logic [2:0]          f3;
    logic [REG_ADDR-1:0] rs1;
    logic [REG_ADDR-1:0] rs2;
    logic [REG_ADDR-1:0] rd;
    logic [WIDTH-1:0]    rd1;
    logic [WIDTH-1:0]    rd2;
    logic [WIDTH-1:0]    imm_ext;
    logic [WIDTH-1:0]    pc;
    logic [WIDTH-1:0]    pc_plus4;
  } ex_word_t;

  ex_word_t             ex_q, ex_d;
  logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;
  logic                 lw_stall;
  logic                 insert_bubble;

  // Load-use hazard: the load now in EX writes a register the ID instruction reads.
  // reg_wr_e is not checked because a load always writes its rd.
  always_comb begin
    lw_stall = ex_q.valid && (ex_q.reg_source == 2'b01) && (ex_q.rd != '0) && bus.valid_d &&
               ((ex_q.rd == bus.rs1_d) || (ex_q.rd == bus.rs2_d));
    insert_bubble = bus.flush_e || lw_stall;
  end

  // Next EX word and bubble count: a flush or load-use hazard inserts one counted bubble.
  always_comb begin
    ex_d         = '0;
    bubble_cnt_d = bubble_cnt_q;
    if (insert_bubble) begin
      if (bubble_cnt_q != {CNT_WIDTH{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
    end else begin
      ex_d.valid       = bus.valid_d;
      ex_d.reg_wr      = bus.reg_wr_d;
      ex_d.alu_source  = bus.ALU_source_d;
      ex_d.mem_wr      = bus.mem_wr_d;
      ex_d.pc_source2  = bus.pc_source2_d;
      ex_d.reg_source  = bus.reg_source_d;
      ex_d.alu_control = bus.ALU_control_d;
      ex_d.branch      = bus.branch_d;
      ex_d.jump        = bus.jump_d;
      ex_d.f3          = bus.f3_d;
      ex_d.rs1         = bus.rs1_d;
      ex_d.rs2         = bus.rs2_d;
      ex_d.rd          = bus.rd_d;
      ex_d.rd1         = bus.rd1_d;
      ex_d.rd2         = bus.rd2_d;
      ex_d.imm_ext     = bus.imm_ext_d;
      ex_d.pc          = bus.pc_d;
      ex_d.pc_plus4    = bus.pc_plus4_d;
    end
  end

  // EX stage register; it always advances, reset clears it to a NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Output mapping; the flush squashes the wrong-path ID instruction, so it also drops the stall.
  always_comb begin
    bus.stall_f       = lw_stall && !bus.flush_e;
    bus.stall_d       = lw_stall && !bus.flush_e;
    bus.bubble_cnt    = bubble_cnt_q;
    bus.valid_e       = ex_q.valid;
    bus.reg_wr_e      = ex_q.reg_wr;
    bus.ALU_source_e  = ex_q.alu_source;
    bus.mem_wr_e      = ex_q.mem_wr;
    bus.pc_source2_e  = ex_q.pc_source2;
    bus.reg_source_e  = ex_q.reg_source;
    bus.ALU_control_e = ex_q.alu_control;
    bus.branch_e      = ex_q.branch;
    bus.jump_e        = ex_q.jump;
    bus.f3_e          = ex_q.f3;
    bus.rs1_e         = ex_q.rs1;
    bus.rs2_e         = ex_q.rs2;
    bus.rd_e          = ex_q.rd;
    bus.rd1_e         = ex_q.rd1;
    bus.rd2_e         = ex_q.rd2;
    bus.imm_ext_e     = ex_q.imm_ext;
    bus.pc_e          = ex_q.pc;
    bus.pc_plus4_e    = ex_q.pc_plus4;
  end

endmodule

// File: tb/tb_pl_id_ex_stage.sv
// tb/tb_pl_id_ex_stage.sv - directed self-checking bench for pl_id_ex_stage
module tb_pl_id_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pl_id_ex_if #(.WIDTH(32), .REG_ADDR(5), .CNT_WIDTH(16)) bus ();
  pl_id_ex_if #(.WIDTH(32), .REG_ADDR(5), .CNT_WIDTH(4))  sbus ();

  pl_id_ex_stage #(.WIDTH(32), .REG_ADDR(5), .CNT_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pl_id_ex_stage #(.WIDTH(32), .REG_ADDR(5), .CNT_WIDTH(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush_e = 0; bus.valid_d = 0; bus.reg_wr_d = 0; bus.ALU_source_d = 0;
    bus.mem_wr_d = 0; bus.pc_source2_d = 0; bus.reg_source_d = 2'b00;
    bus.ALU_control_d = 3'b000; bus.branch_d = 0; bus.jump_d = 0; bus.f3_d = 3'b000;
    bus.rs1_d = 0; bus.rs2_d = 0; bus.rd_d = 0; bus.rd1_d = 0; bus.rd2_d = 0;
    bus.imm_ext_d = 0; bus.pc_d = 0; bus.pc_plus4_d = 0;
  endtask

  task automatic clear_small();
    sbus.flush_e = 0; sbus.valid_d = 0; sbus.reg_wr_d = 0; sbus.ALU_source_d = 0;
    sbus.mem_wr_d = 0; sbus.pc_source2_d = 0; sbus.reg_source_d = 2'b00;
    sbus.ALU_control_d = 3'b000; sbus.branch_d = 0; sbus.jump_d = 0; sbus.f3_d = 3'b000;
    sbus.rs1_d = 0; sbus.rs2_d = 0; sbus.rd_d = 0; sbus.rd1_d = 0; sbus.rd2_d = 0;
    sbus.imm_ext_d = 0; sbus.pc_d = 0; sbus.pc_plus4_d = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    bus.valid_d = 1; bus.reg_wr_d = 1; bus.mem_wr_d = 1; bus.rd_d = 5'd9; bus.rd1_d = 32'hdead;
    step();
    step();
    n_cmp++; if (bus.valid_e !== 1'b0) begin n_fail++; $display("FAIL reset_valid_e got %0h want 0", bus.valid_e); end
    n_cmp++; if (bus.reg_wr_e !== 1'b0) begin n_fail++; $display("FAIL reset_reg_wr_e got %0h want 0", bus.reg_wr_e); end
    n_cmp++; if (bus.mem_wr_e !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr_e got %0h want 0", bus.mem_wr_e); end
    n_cmp++; if (bus.rd_e !== 5'd0) begin n_fail++; $display("FAIL reset_rd_e got %0h want 0", bus.rd_e); end
    n_cmp++; if (bus.rd1_e !== 32'd0) begin n_fail++; $display("FAIL reset_rd1_e got %0h want 0", bus.rd1_e); end
    n_cmp++; if (bus.bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_bubble_cnt got %0d want 0", bus.bubble_cnt); end
    n_cmp++; if (bus.stall_f !== 1'b0) begin n_fail++; $display("FAIL reset_stall_f got %0h want 0", bus.stall_f); end
  endtask

  task automatic test_plain_flow();
    clear_inputs();
    rst = 0;
    bus.valid_d = 1; bus.reg_wr_d = 1; bus.ALU_control_d = 3'b000; bus.rd_d = 5'd5;
    bus.rd1_d = 32'h10; bus.rd2_d = 32'h20;
    step();
    n_cmp++; if (bus.reg_wr_e !== 1'b1) begin n_fail++; $display("FAIL flow_reg_wr_e got %0h want 1", bus.reg_wr_e); end
    n_cmp++; if (bus.rd_e !== 5'd5) begin n_fail++; $display("FAIL flow_rd_e got %0d want 5", bus.rd_e); end
    n_cmp++; if (bus.rd1_e !== 32'h10) begin n_fail++; $display("FAIL flow_rd1_e got %0h want 10", bus.rd1_e); end
    n_cmp++; if (bus.rd2_e !== 32'h20) begin n_fail++; $display("FAIL flow_rd2_e got %0h want 20", bus.rd2_e); end
    n_cmp++; if (bus.valid_e !== 1'b1) begin n_fail++; $display("FAIL flow_valid_e got %0h want 1", bus.valid_e); end
    n_cmp++; if (bus.stall_f !== 1'b0) begin n_fail++; $display("FAIL flow_stall_f got %0h want 0", bus.stall_f); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.valid_d = 1; bus.reg_wr_d = 1; bus.reg_source_d = 2'b01; bus.rd_d = 5'd7;
    step();
    clear_inputs();
    bus.valid_d = 1; bus.reg_wr_d = 1; bus.rs1_d = 5'd7; bus.rs2_d = 5'd2; bus.rd_d = 5'd8;
    #1;
    n_cmp++; if (bus.stall_f !== 1'b1) begin n_fail++; $display("FAIL lu_stall_f got %0h want 1", bus.stall_f); end
    n_cmp++; if (bus.stall_d !== 1'b1) begin n_fail++; $display("FAIL lu_stall_d got %0h want 1", bus.stall_d); end
    step();
    n_cmp++; if (bus.valid_e !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid_e got %0h want 0", bus.valid_e); end
    n_cmp++; if (bus.reg_wr_e !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_reg_wr_e got %0h want 0", bus.reg_wr_e); end
    n_cmp++; if (bus.bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_bubble_cnt got %0d want 1", bus.bubble_cnt); end
    n_cmp++; if (bus.stall_f !== 1'b0) begin n_fail++; $display("FAIL lu_release_stall_f got %0h want 0", bus.stall_f); end
    step();
    n_cmp++; if (bus.valid_e !== 1'b1) begin n_fail++; $display("FAIL lu_add_valid_e got %0h want 1", bus.valid_e); end
    n_cmp++; if (bus.rs1_e !== 5'd7) begin n_fail++; $display("FAIL lu_add_rs1_e got %0d want 7", bus.rs1_e); end
    n_cmp++; if (bus.rd_e !== 5'd8) begin n_fail++; $display("FAIL lu_add_rd_e got %0d want 8", bus.rd_e); end
  endtask

  task automatic test_no_stall();
    clear_inputs();
    bus.valid_d = 1; bus.reg_wr_d = 1; bus.reg_source_d = 2'b01; bus.rd_d = 5'd0;
    step();
    clear_inputs();
    bus.valid_d = 1; bus.reg_wr_d = 1; bus.rs1_d = 5'd0; bus.rs2_d = 5'd0; bus.rd_d = 5'd7;
    #1;
    n_cmp++; if (bus.stall_f !== 1'b0) begin n_fail++; $display("FAIL ns_x0_stall_f got %0h want 0", bus.stall_f); end
    step();
    clear_inputs();
    bus.valid_d = 1; bus.reg_wr_d = 1; bus.rs1_d = 5'd7; bus.rs2_d = 5'd7; bus.rd_d = 5'd3;
    #1;
    n_cmp++; if (bus.stall_f !== 1'b0) begin n_fail++; $display("FAIL ns_alu_stall_f got %0h want 0", bus.stall_f); end
    step();
    n_cmp++; if (bus.bubble_cnt !== 16'd1) begin n_fail++; $display("FAIL ns_bubble_cnt got %0d want 1", bus.bubble_cnt); end
    n_cmp++; if (bus.valid_e !== 1'b1) begin n_fail++; $display("FAIL ns_valid_e got %0h want 1", bus.valid_e); end
  endtask

  task automatic test_flush();
    clear_inputs();
    bus.valid_d = 1; bus.mem_wr_d = 1; bus.rs1_d = 5'd4; bus.rs2_d = 5'd6; bus.flush_e = 1;
    step();
    n_cmp++; if (bus.mem_wr_e !== 1'b0) begin n_fail++; $display("FAIL fl_mem_wr_e got %0h want 0", bus.mem_wr_e); end
    n_cmp++; if (bus.valid_e !== 1'b0) begin n_fail++; $display("FAIL fl_valid_e got %0h want 0", bus.valid_e); end
    n_cmp++; if (bus.bubble_cnt !== 16'd2) begin n_fail++; $display("FAIL fl_bubble_cnt got %0d want 2", bus.bubble_cnt); end
    clear_inputs();
    bus.valid_d = 1; bus.reg_wr_d = 1; bus.reg_source_d = 2'b01; bus.rd_d = 5'd9;
    step();
    clear_inputs();
    bus.valid_d = 1; bus.rs2_d = 5'd9; bus.flush_e = 1;
    #1;
    n_cmp++; if (bus.stall_f !== 1'b0) begin n_fail++; $display("FAIL fllu_stall_f got %0h want 0", bus.stall_f); end
    n_cmp++; if (bus.stall_d !== 1'b0) begin n_fail++; $display("FAIL fllu_stall_d got %0h want 0", bus.stall_d); end
    step();
    n_cmp++; if (bus.bubble_cnt !== 16'd3) begin n_fail++; $display("FAIL fllu_bubble_cnt got %0d want 3", bus.bubble_cnt); end
    n_cmp++; if (bus.valid_e !== 1'b0) begin n_fail++; $display("FAIL fllu_valid_e got %0h want 0", bus.valid_e); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    bus.valid_d = 1; bus.branch_d = 1; bus.f3_d = 3'b101; bus.ALU_control_d = 3'b111;
    bus.ALU_source_d = 1; bus.imm_ext_d = 32'hfffffff0; bus.pc_d = 32'h100; bus.pc_plus4_d = 32'h104;
    bus.rs1_d = 5'd1; bus.rs2_d = 5'd2;
    step();
    clear_inputs();
    bus.valid_d = 1; bus.jump_d = 1; bus.pc_source2_d = 1; bus.reg_wr_d = 1; bus.reg_source_d = 2'b10;
    bus.rd_d = 5'd1; bus.pc_d = 32'h104; bus.pc_plus4_d = 32'h108; bus.imm_ext_d = 32'h40;
    n_cmp++; if (bus.branch_e !== 1'b1) begin n_fail++; $display("FAIL b2b_branch_e got %0h want 1", bus.branch_e); end
    n_cmp++; if (bus.f3_e !== 3'b101) begin n_fail++; $display("FAIL b2b_f3_e got %0h want 5", bus.f3_e); end
    n_cmp++; if (bus.ALU_control_e !== 3'b111) begin n_fail++; $display("FAIL b2b_alu_ctrl_e got %0h want 7", bus.ALU_control_e); end
    n_cmp++; if (bus.ALU_source_e !== 1'b1) begin n_fail++; $display("FAIL b2b_alu_src_e got %0h want 1", bus.ALU_source_e); end
    n_cmp++; if (bus.imm_ext_e !== 32'hfffffff0) begin n_fail++; $display("FAIL b2b_imm_e got %0h want fffffff0", bus.imm_ext_e); end
    n_cmp++; if (bus.pc_e !== 32'h100) begin n_fail++; $display("FAIL b2b_pc_e got %0h want 100", bus.pc_e); end
    n_cmp++; if (bus.pc_plus4_e !== 32'h104) begin n_fail++; $display("FAIL b2b_pc4_e got %0h want 104", bus.pc_plus4_e); end
    n_cmp++; if (bus.rs2_e !== 5'd2) begin n_fail++; $display("FAIL b2b_rs2_e got %0d want 2", bus.rs2_e); end
    step();
    n_cmp++; if (bus.jump_e !== 1'b1) begin n_fail++; $display("FAIL b2b_jump_e got %0h want 1", bus.jump_e); end
    n_cmp++; if (bus.branch_e !== 1'b0) begin n_fail++; $display("FAIL b2b_branch2_e got %0h want 0", bus.branch_e); end
    n_cmp++; if (bus.pc_source2_e !== 1'b1) begin n_fail++; $display("FAIL b2b_pcsrc2_e got %0h want 1", bus.pc_source2_e); end
    n_cmp++; if (bus.reg_source_e !== 2'b10) begin n_fail++; $display("FAIL b2b_regsrc_e got %0h want 2", bus.reg_source_e); end
    n_cmp++; if (bus.pc_plus4_e !== 32'h108) begin n_fail++; $display("FAIL b2b_pc4_2_e got %0h want 108", bus.pc_plus4_e); end
    n_cmp++; if (bus.imm_ext_e !== 32'h40) begin n_fail++; $display("FAIL b2b_imm2_e got %0h want 40", bus.imm_ext_e); end
    clear_inputs();
    bus.valid_d = 0; bus.reg_wr_d = 1; bus.rd_d = 5'd12;
    step();
    n_cmp++; if (bus.valid_e !== 1'b0) begin n_fail++; $display("FAIL b2b_ifbubble_valid_e got %0h want 0", bus.valid_e); end
    n_cmp++; if (bus.rd_e !== 5'd12) begin n_fail++; $display("FAIL b2b_ifbubble_rd_e got %0d want 12", bus.rd_e); end
    n_cmp++; if (bus.bubble_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_ifbubble_cnt got %0d want 3", bus.bubble_cnt); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    sbus.flush_e = 1;
    for (int i = 0; i < 15; i++) step();
    n_cmp++; if (sbus.bubble_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach got %0d want 15", sbus.bubble_cnt); end
    for (int i = 0; i < 5; i++) step();
    n_cmp++; if (sbus.bubble_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d want 15", sbus.bubble_cnt); end
    sbus.flush_e = 0;
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    bus.valid_d = 1; bus.reg_wr_d = 1; bus.reg_source_d = 2'b01; bus.rd_d = 5'd3;
    step();
    clear_inputs();
    bus.valid_d = 1; bus.rs1_d = 5'd3;
    #1;
    n_cmp++; if (bus.stall_f !== 1'b1) begin n_fail++; $display("FAIL rms_pre_stall_f got %0h want 1", bus.stall_f); end
    rst = 1;
    step();
    n_cmp++; if (bus.stall_f !== 1'b0) begin n_fail++; $display("FAIL rms_stall_f got %0h want 0", bus.stall_f); end
    n_cmp++; if (bus.valid_e !== 1'b0) begin n_fail++; $display("FAIL rms_valid_e got %0h want 0", bus.valid_e); end
    n_cmp++; if (bus.bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL rms_bubble_cnt got %0d want 0", bus.bubble_cnt); end
    rst = 0;
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    clear_small();
    test_reset();
    test_plain_flow();
    test_load_use();
    test_no_stall();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
